// File: rtl/gpio_config_loader_pkg.sv
// ----------------------------------------------------------------------------
// gpio_cfg_pkg
// Shared definitions for the per-pad GPIO configuration loader:
//   - configuration word width and the bit position of every pad field
//   - drive-mode (DM) encodings for the 3-bit gpio_dm field
//   - the chip-level default configuration word
//   - the loader state type, derived from the shift count
// No ports (package).
// ----------------------------------------------------------------------------
package gpio_cfg_pkg;

  localparam int CFG_W = 13;

  // Bit positions of the single-bit fields inside the configuration word.
  localparam int MGMT_ENA       = 0;
  localparam int OUTENB         = 1;
  localparam int HOLDOVER       = 2;
  localparam int INP_DIS        = 3;
  localparam int IB_MODE_SEL    = 4;
  localparam int ANA_EN         = 5;
  localparam int ANA_SEL        = 6;
  localparam int ANA_POL        = 7;
  localparam int SLOW_SEL       = 8;
  localparam int VTRIP_SEL      = 9;
  localparam int DM_LSB         = 10;
  localparam int DM_W           = 3;

  // Drive-mode encodings for gpio_dm.
  localparam logic [DM_W-1:0] DM_ANALOG          = 3'b000;
  localparam logic [DM_W-1:0] DM_INPUT_NOPULL    = 3'b001;
  localparam logic [DM_W-1:0] DM_INPUT_PULLDOWN  = 3'b010;
  localparam logic [DM_W-1:0] DM_INPUT_PULLUP    = 3'b011;
  localparam logic [DM_W-1:0] DM_OPEN_DRAIN_LOW  = 3'b100;
  localparam logic [DM_W-1:0] DM_OPEN_DRAIN_HIGH = 3'b101;
  localparam logic [DM_W-1:0] DM_STRONG          = 3'b110;
  localparam logic [DM_W-1:0] DM_WEAK            = 3'b111;

  // Chip default: output disabled, input with no pull.
  localparam logic [CFG_W-1:0] CFG_CHIP_DEFAULT = 13'h0402;

  // Shift count at which a full word has been received.
  localparam logic [3:0] CNT_FULL = 4'd13;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    ARMED   = 2'd2
  } cfg_state_e;

  // Map the shift count onto the loader state.
  function automatic cfg_state_e state_from_count(input logic [3:0] cnt);
    if (cnt == 4'd0)          return EMPTY;
    else if (cnt >= CNT_FULL) return ARMED;
    else                      return FILLING;
  endfunction

endpackage

// File: rtl/gpio_config_loader_if.sv
// ----------------------------------------------------------------------------
// gpio_cfg_if
// Housekeeping serial-programming bus of one pad in the daisy chain.
//   serial_shift    : shift strobe, serial_data_in enters this cycle
//   serial_data_in  : bit from the previous pad, MSB first
//   serial_load     : one-cycle commit strobe
//   defaults_reload : request to restore the tie-cell defaults
//   serial_data_out : MSB of the shift register, to the next pad
// Modports: master = housekeeping side, slave = loader side.
// ----------------------------------------------------------------------------
interface gpio_cfg_if;

  logic serial_shift;
  logic serial_data_in;
  logic serial_load;
  logic defaults_reload;
  logic serial_data_out;

  modport master (
    output serial_shift,
    output serial_data_in,
    output serial_load,
    output defaults_reload,
    input  serial_data_out
  );

  modport slave (
    input  serial_shift,
    input  serial_data_in,
    input  serial_load,
    input  defaults_reload,
    output serial_data_out
  );

endinterface

// File: rtl/gpio_config_loader_shift_reg.sv
// ----------------------------------------------------------------------------
// gpio_cfg_shift_reg
// Serial shift register and saturating bit counter of the config loader.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   defaults          : tie-cell default word, loaded on reset / reload
//   reload            : restore defaults, clear count
//   load              : commit strobe; clears count and blocks the shift
//   shift, data_in    : shift strobe and serial bit (MSB first)
//   shift_q           : current shift register contents
//   armed             : a full word has been shifted in since the last clear
// ----------------------------------------------------------------------------
module gpio_cfg_shift_reg
  import gpio_cfg_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CFG_W-1:0] defaults,
  input  logic             reload,
  input  logic             load,
  input  logic             shift,
  input  logic             data_in,
  output logic [CFG_W-1:0] shift_q,
  output logic             armed
);

  logic [CFG_W-1:0] shift_d;
  logic [3:0]       cnt_q;
  logic [3:0]       cnt_d;
  cfg_state_e       state;

  // State register: shift word and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= defaults;
      cnt_q   <= 4'd0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state. A load always clears the count (accepted or not) and
  // suppresses any simultaneous shift so the committed word is the
  // pre-shift value. The count saturates because the whole chain streams
  // through every pad, so more than 13 shifts is normal.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (reload) begin
      shift_d = defaults;
      cnt_d   = 4'd0;
    end else if (load) begin
      cnt_d   = 4'd0;
    end else if (shift) begin
      shift_d = {shift_q[CFG_W-2:0], data_in};
      if (cnt_q < CNT_FULL) cnt_d = cnt_q + 4'd1;
    end
  end

  // Output decode of the derived state.
  always_comb begin
    state = state_from_count(cnt_q);
    armed = (state == ARMED);
  end

endmodule

// File: rtl/gpio_config_loader.sv
// ----------------------------------------------------------------------------
// gpio_config_loader
// Per-pad configuration holder: loads the tie-cell defaults at reset,
// accepts serial reprogramming through a daisy chain and commits a new
// word on a load strobe.
// Ports:
//   serial_clock      : sole clock (rising edge)
//   resetn            : asynchronous active-low reset
//   gpio_defaults     : static default word from the tie-cell block
//   bus               : serial programming bus (gpio_cfg_if.slave)
//   gpio_config       : committed configuration word
//   mgmt_ena .. gpio_vtrip_sel : gpio_config bits 0..9
//   gpio_dm           : gpio_config[12:10]
//   load_done         : one-cycle pulse on an accepted commit
//   cfg_err           : sticky flag for a rejected commit
// ----------------------------------------------------------------------------
module gpio_config_loader
  import gpio_cfg_pkg::*;
(
  input  logic             serial_clock,
  input  logic             resetn,
  input  logic [CFG_W-1:0] gpio_defaults,
  gpio_cfg_if.slave        bus,
  output logic [CFG_W-1:0] gpio_config,
  output logic             mgmt_ena,
  output logic             gpio_outenb,
  output logic             gpio_holdover,
  output logic             gpio_inp_dis,
  output logic             gpio_ib_mode_sel,
  output logic             gpio_ana_en,
  output logic             gpio_ana_sel,
  output logic             gpio_ana_pol,
  output logic             gpio_slow_sel,
  output logic             gpio_vtrip_sel,
  output logic [DM_W-1:0]  gpio_dm,
  output logic             load_done,
  output logic             cfg_err
);

  logic [CFG_W-1:0] shift_q;
  logic             armed;
  logic [CFG_W-1:0] cfg_q;
  logic             err_q;
  logic             done_q;

  gpio_cfg_shift_reg u_shift (
    .clk      (serial_clock),
    .rst_n    (resetn),
    .defaults (gpio_defaults),
    .reload   (bus.defaults_reload),
    .load     (bus.serial_load),
    .shift    (bus.serial_shift),
    .data_in  (bus.serial_data_in),
    .shift_q  (shift_q),
    .armed    (armed)
  );

  // Committed word, error and done flags. Reload outranks a commit and
  // produces no done pulse; a load without a full word is rejected.
  always_ff @(posedge serial_clock or negedge resetn) begin
    if (!resetn) begin
      cfg_q  <= gpio_defaults;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.defaults_reload) begin
        cfg_q <= gpio_defaults;
        err_q <= 1'b0;
      end else if (bus.serial_load && armed) begin
        cfg_q  <= shift_q;
        err_q  <= 1'b0;
        done_q <= 1'b1;
      end else if (bus.serial_load) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.serial_data_out = shift_q[CFG_W-1];
  assign gpio_config         = cfg_q;
  assign load_done           = done_q;
  assign cfg_err             = err_q;

  assign mgmt_ena         = cfg_q[MGMT_ENA];
  assign gpio_outenb      = cfg_q[OUTENB];
  assign gpio_holdover    = cfg_q[HOLDOVER];
  assign gpio_inp_dis     = cfg_q[INP_DIS];
  assign gpio_ib_mode_sel = cfg_q[IB_MODE_SEL];
  assign gpio_ana_en      = cfg_q[ANA_EN];
  assign gpio_ana_sel     = cfg_q[ANA_SEL];
  assign gpio_ana_pol     = cfg_q[ANA_POL];
  assign gpio_slow_sel    = cfg_q[SLOW_SEL];
  assign gpio_vtrip_sel   = cfg_q[VTRIP_SEL];
  assign gpio_dm          = cfg_q[DM_LSB +: DM_W];

endmodule

// File: tb/tb_gpio_config_loader.sv
// ----------------------------------------------------------------------------
// tb_gpio_config_loader
// Directed self-checking bench for gpio_config_loader.
// ----------------------------------------------------------------------------
module tb_gpio_config_loader;
  import gpio_cfg_pkg::*;

  logic             serial_clock;
  logic             resetn;
  logic [CFG_W-1:0] gpio_defaults;
  logic [CFG_W-1:0] gpio_config;
  logic             mgmt_ena, gpio_outenb, gpio_holdover, gpio_inp_dis;
  logic             gpio_ib_mode_sel, gpio_ana_en, gpio_ana_sel, gpio_ana_pol;
  logic             gpio_slow_sel, gpio_vtrip_sel;
  logic [2:0]       gpio_dm;
  logic             load_done;
  logic             cfg_err;

  int errors = 0;
  int checks = 0;

  gpio_cfg_if bus ();

  gpio_config_loader dut (
    .serial_clock     (serial_clock),
    .resetn           (resetn),
    .gpio_defaults    (gpio_defaults),
    .bus              (bus),
    .gpio_config      (gpio_config),
    .mgmt_ena         (mgmt_ena),
    .gpio_outenb      (gpio_outenb),
    .gpio_holdover    (gpio_holdover),
    .gpio_inp_dis     (gpio_inp_dis),
    .gpio_ib_mode_sel (gpio_ib_mode_sel),
    .gpio_ana_en      (gpio_ana_en),
    .gpio_ana_sel     (gpio_ana_sel),
    .gpio_ana_pol     (gpio_ana_pol),
    .gpio_slow_sel    (gpio_slow_sel),
    .gpio_vtrip_sel   (gpio_vtrip_sel),
    .gpio_dm          (gpio_dm),
    .load_done        (load_done),
    .cfg_err          (cfg_err)
  );

  initial serial_clock = 1'b0;
  always #5 serial_clock = ~serial_clock;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [12:0] actual,
                             input logic [12:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, then move to 1 time unit after the edge.
  task automatic applyStimulus(input logic shift, input logic din,
                               input logic load, input logic reload);
    bus.serial_shift    = shift;
    bus.serial_data_in  = din;
    bus.serial_load     = load;
    bus.defaults_reload = reload;
    @(posedge serial_clock);
    #1;
    bus.serial_shift    = 1'b0;
    bus.serial_data_in  = 1'b0;
    bus.serial_load     = 1'b0;
    bus.defaults_reload = 1'b0;
  endtask

  // Shift the low n bits of a word, MSB first.
  task automatic shiftWord(input logic [19:0] word, input int n);
    for (int i = n - 1; i >= 0; i--) applyStimulus(1'b1, word[i], 1'b0, 1'b0);
  endtask

  logic [19:0] word20;

  initial begin
    bus.serial_shift    = 1'b0;
    bus.serial_data_in  = 1'b0;
    bus.serial_load     = 1'b0;
    bus.defaults_reload = 1'b0;
    gpio_defaults       = 13'h0402;
    resetn              = 1'b0;
    #12;

    // Reset state
    checkOutput("rst_config", gpio_config, 13'h0402);
    checkOutput("rst_dm", 13'(gpio_dm), 13'h1);
    checkOutput("rst_outenb", 13'(gpio_outenb), 13'h1);
    checkOutput("rst_sdo", 13'(bus.serial_data_out), 13'h0);
    checkOutput("rst_err", 13'(cfg_err), 13'h0);
    checkOutput("rst_done", 13'(load_done), 13'h0);
    #5 resetn = 1'b1;
    @(posedge serial_clock); #1;

    // Full word commit
    shiftWord(20'h01803, 13);
    checkOutput("pre_load_config", gpio_config, 13'h0402);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("load1_config", gpio_config, 13'h1803);
    checkOutput("load1_mgmt", 13'(mgmt_ena), 13'h1);
    checkOutput("load1_dm", 13'(gpio_dm), 13'h6);
    checkOutput("load1_done", 13'(load_done), 13'h1);
    checkOutput("load1_err", 13'(cfg_err), 13'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("load1_done_pulse", 13'(load_done), 13'h0);

    // 20 shifts: the first 7 bits pass through to the next pad
    word20 = {7'b1011001, 13'h0007};
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b1, word20[20-k], 1'b0, 1'b0);
      if (k >= 13 && k <= 19)
        checkOutput($sformatf("passthru_k%0d", k), 13'(bus.serial_data_out),
                    13'(word20[19-(k-13)]));
    end
    checkOutput("passthru_config_held", gpio_config, 13'h1803);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("load20_config", gpio_config, 13'h0007);
    checkOutput("load20_dm", 13'(gpio_dm), 13'h0);
    checkOutput("load20_holdover", 13'(gpio_holdover), 13'h1);
    checkOutput("load20_done", 13'(load_done), 13'h1);

    // Partial word is rejected, error is sticky, then cleared by a good load
    shiftWord(20'h0001F, 5);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("short_config", gpio_config, 13'h0007);
    checkOutput("short_err", 13'(cfg_err), 13'h1);
    checkOutput("short_done", 13'(load_done), 13'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("short_err_sticky", 13'(cfg_err), 13'h1);
    shiftWord(20'h00A55, 13);
    checkOutput("err_held_while_shift", 13'(cfg_err), 13'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("recover_config", gpio_config, 13'h0A55);
    checkOutput("recover_err", 13'(cfg_err), 13'h0);
    checkOutput("recover_done", 13'(load_done), 13'h1);

    // Load with simultaneous shift commits the pre-shift word
    shiftWord(20'h01234, 13);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("ldshift_config", gpio_config, 13'h1234);
    checkOutput("ldshift_noshift_sdo", 13'(bus.serial_data_out), 13'h1);
    checkOutput("ldshift_done", 13'(load_done), 13'h1);

    // Reload outranks an armed load
    shiftWord(20'h00F0F, 13);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("reload_config", gpio_config, 13'h0402);
    checkOutput("reload_done", 13'(load_done), 13'h0);
    checkOutput("reload_err", 13'(cfg_err), 13'h0);
    checkOutput("reload_sdo", 13'(bus.serial_data_out), 13'h0);

    // Back-to-back loads: the second one is rejected
    shiftWord(20'h01AAA, 13);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("b2b_first_config", gpio_config, 13'h1AAA);
    checkOutput("b2b_first_done", 13'(load_done), 13'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("b2b_second_err", 13'(cfg_err), 13'h1);
    checkOutput("b2b_second_done", 13'(load_done), 13'h0);
    checkOutput("b2b_second_config", gpio_config, 13'h1AAA);

    // Asynchronous reset in the middle of a shift sequence
    shiftWord(20'h0007F, 7);
    checkOutput("midshift_sdo", 13'(bus.serial_data_out), 13'h1);
    #2 resetn = 1'b0;
    #1;
    checkOutput("async_rst_config", gpio_config, 13'h0402);
    checkOutput("async_rst_sdo", 13'(bus.serial_data_out), 13'h0);
    checkOutput("async_rst_err", 13'(cfg_err), 13'h0);
    checkOutput("async_rst_dm", 13'(gpio_dm), 13'h1);
    @(posedge serial_clock); #3;
    resetn = 1'b1;
    @(posedge serial_clock); #1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("post_rst_load_err", 13'(cfg_err), 13'h1);
    checkOutput("post_rst_load_config", gpio_config, 13'h0402);
    checkOutput("post_rst_load_done", 13'(load_done), 13'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpio_config_loader.md
# gpio_config_loader

Per-pad configuration loader that consumes the 13-bit mask-programmed default word from the pad's defaults tie-cell block and holds the live pad configuration. It loads the defaults at reset, accepts serial reprogramming from housekeeping over a daisy-chained shift interface, and commits a new word on a load strobe. It sits between the defaults tie-cell block and the GPIO pad cell, one instance per user pad.

## Interface
- `CFG_W`, 13: configuration word width; fixed, not overridable in practice.
- `serial_clock`  in  1  sole clock; all state is on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `gpio_defaults`  in  13  default word; static tie-cell value.
- `serial_shift`  in  1  shift strobe; when high, `serial_data_in` is shifted in this cycle.
- `serial_data_in`  in  1  serial bit from the previous pad in the chain, MSB first.
- `serial_load`  in  1  commit strobe, one cycle.
- `defaults_reload`  in  1  synchronous request to restore `gpio_defaults`.
- `serial_data_out`  out  1  bit 12 of the shift register, feeding the next pad.
- `gpio_config`  out  13  committed configuration word.
- `mgmt_ena, gpio_outenb, gpio_holdover, gpio_inp_dis, gpio_ib_mode_sel, gpio_ana_en, gpio_ana_sel, gpio_ana_pol, gpio_slow_sel, gpio_vtrip_sel`  out  1 each  `gpio_config` bits 0 to 9, in that order.
- `gpio_dm`  out  3  `gpio_config[12:10]`.
- `load_done`  out  1  one-cycle pulse when a commit is accepted.
- `cfg_err`  out  1  sticky flag for a rejected commit.

## Operation
- Registers: `shift_q[12:0]`, `cfg_q[12:0]`, `cnt_q[3:0]` (saturates at 13), `err_q`, `done_q`.
- Reset (asynchronous): `shift_q`=`cfg_q`=`gpio_defaults`, `cnt_q`=0, `cfg_err`=0, `load_done`=0. `serial_data_out` therefore resets to `gpio_defaults[12]`.
- State, derived from `cnt_q`:
  - EMPTY when `cnt_q`=0.
  - FILLING when `cnt_q` is 1 to 12.
  - ARMED when `cnt_q`=13.
- Per-cycle priority, highest first:
  1. `defaults_reload`: `shift_q` and `cfg_q` take `gpio_defaults`, `cnt_q`=0, `err_q`=0. No `load_done` pulse.
  2. `serial_load` in ARMED: `cfg_q`=`shift_q` (the pre-shift value), `cnt_q`=0, `err_q`=0, `load_done`=1.
  3. `serial_load` in EMPTY or FILLING: `cfg_q` unchanged, `err_q`=1, `cnt_q`=0, no pulse.
  4. `serial_shift`: `shift_q`={`shift_q[11:0]`, `serial_data_in`}; `cnt_q` increments, saturating at 13.
- When `serial_load` is asserted, any simultaneous `serial_shift` is ignored for that cycle.
- More than 13 shifts is normal, because the whole chain passes through every pad. The word committed is the last 13 bits shifted in.
- All config outputs are direct decodes of `cfg_q`. They only change on reset, reload, or an accepted commit.

## Timing
- Shift: `serial_data_out` shows a new `shift_q[12]` one cycle after each `serial_shift`. A bit entered on shift k appears at `serial_data_out` after shift k+12.
- Commit: `gpio_config` and `load_done` are both valid on the edge after `serial_load` is sampled. `load_done` is high for exactly one cycle.
- `cfg_err` is set on the edge after a rejected load. It clears on the next accepted load, on reload, or on reset.
- Reset asserted mid-shift abandons the partial word and returns the block to defaults immediately, without waiting for a clock edge.
- Back-to-back `serial_load`: the second load finds `cnt_q`=0, so it is rejected and `cfg_err` is set.

## Structure
- Package `gpio_cfg_pkg` holds:
  - `CFG_W`=13 and the bit indices (MGMT_ENA=0 … VTRIP_SEL=9, DM_LSB=10).
  - The DM encodings (e.g. DM_INPUT_NOPULL=3'b001).
  - The chip default constant 13'h0402.
- One sub-module, `gpio_cfg_shift_reg`, contains `shift_q`, `cnt_q`, and the ARMED flag.
- The top level holds `cfg_q`, the error and done logic, and the field decode.

## Test plan
- Reset with `gpio_defaults`=13'h0402 → `gpio_config`=13'h0402, `gpio_dm`=3'b001, `gpio_outenb`=1, `serial_data_out`=0, `cfg_err`=0.
- Shift 13'h1803 in MSB first, then pulse `serial_load` → one cycle later `gpio_config`=13'h1803, `mgmt_ena`=1, `gpio_dm`=3'b110, one `load_done` pulse.
- Shift 20 bits whose last 13 are 13'h0007, then load → `gpio_config`=13'h0007. The first 7 bits appear on `serial_data_out` after shifts 13 to 19.
- Shift 5 bits, then load → `gpio_config` unchanged, `cfg_err`=1. Then shift 13 bits and load → `cfg_err`=0 and the new word is committed.
- Assert `serial_load` and `serial_shift` together in ARMED → the pre-shift word is committed and `shift_q` is not shifted. Assert `defaults_reload` together with `serial_load` → `gpio_config`=`gpio_defaults` and no `load_done`.
- Drop `resetn` after 7 shifts → all outputs return to their default values asynchronously. After release, a load with no shifts is rejected.
